// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the sequential InvMixColumns block:
//   - imc_state_t : FSM state type (IDLE / BUSY / DONE)
//   - NUM_COLS    : number of 32-bit columns in an AES state
//   - RED_POLY    : low byte of the GF(2^8) reduction polynomial 0x11b
//   - COEF_*      : InvMixColumns matrix coefficients
//   - xtime       : multiply a byte by x (i.e. by 02) in GF(2^8)
//   - mul_const   : multiply a byte by a constant using only xtime and XOR
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } imc_state_t;

    localparam int         NUM_COLS = 4;
    localparam logic [7:0] RED_POLY = 8'h1b;

    localparam logic [7:0] COEF_0E = 8'h0e;
    localparam logic [7:0] COEF_0B = 8'h0b;
    localparam logic [7:0] COEF_0D = 8'h0d;
    localparam logic [7:0] COEF_09 = 8'h09;

    // Shift left by one; fold the bit that fell off back in via 0x1b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
    endfunction

    // Constant multiply as a sum of repeated xtime terms. With a constant
    // coefficient this folds down to a small fixed XOR network.
    function automatic logic [7:0] mul_const(input logic [7:0] b,
                                             input logic [7:0] coef);
        logic [7:0] acc;
        logic [7:0] pow;
        acc = 8'h00;
        pow = b;
        for (int i = 0; i < 8; i++) begin
            if (coef[i]) begin
                acc = acc ^ pow;
            end
            pow = xtime(pow);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_column_32bit.sv
// ---------------------------------------------------------------------------
// inv_mix_column_32bit
// Combinational InvMixColumns on one AES column; exact inverse of the
// forward 32-bit MixColumns unit.
//   col_in  [31:0] : input column, byte 0 in bits [31:24]
//   col_out [31:0] : transformed column, same byte layout
// ---------------------------------------------------------------------------
module inv_mix_column_32bit
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Each output row is a circulant rotation of {0e 0b 0d 09}.
    assign col_out[31:24] = mul_const(a0, COEF_0E) ^ mul_const(a1, COEF_0B) ^
                            mul_const(a2, COEF_0D) ^ mul_const(a3, COEF_09);
    assign col_out[23:16] = mul_const(a0, COEF_09) ^ mul_const(a1, COEF_0E) ^
                            mul_const(a2, COEF_0B) ^ mul_const(a3, COEF_0D);
    assign col_out[15:8]  = mul_const(a0, COEF_0D) ^ mul_const(a1, COEF_09) ^
                            mul_const(a2, COEF_0E) ^ mul_const(a3, COEF_0B);
    assign col_out[7:0]   = mul_const(a0, COEF_0B) ^ mul_const(a1, COEF_0D) ^
                            mul_const(a2, COEF_09) ^ mul_const(a3, COEF_0E);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_seq
// Sequential InvMixColumns over a 128-bit AES state, one column per cycle
// through a single shared column unit. Valid/ready on both sides.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : in_data valid this cycle
//   in_ready  : block can accept in_data this cycle
//   in_data   : 128-bit state, column c at [127-32c : 96-32c]
//   out_valid : out_data holds a completed result
//   out_ready : consumer accepts out_data this cycle
//   out_data  : InvMixColumns(in_data), same layout (always the state reg)
// ---------------------------------------------------------------------------
module inv_mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

    imc_state_t   state, state_nxt;
    logic [1:0]   col_cnt;
    logic [127:0] state_reg;
    logic [31:0]  col_sel;
    logic [31:0]  col_mixed;
    logic         accept;

    // Column mux feeding the single shared transform unit.
    always_comb begin
        case (col_cnt)
            2'd0:    col_sel = state_reg[127:96];
            2'd1:    col_sel = state_reg[95:64];
            2'd2:    col_sel = state_reg[63:32];
            default: col_sel = state_reg[31:0];
        endcase
    end

    inv_mix_column_32bit u_col (
        .col_in  (col_sel),
        .col_out (col_mixed)
    );

    // Handshake outputs and next state. In DONE, in_ready follows out_ready
    // so a new block can be loaded on the same edge the result leaves.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (col_cnt == LAST_COL) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_nxt = in_valid ? BUSY : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign out_data = state_reg;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: load on accept, otherwise overwrite one column per BUSY
    // cycle. The 2-bit counter naturally wraps to 0 after column 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt   <= 2'd0;
            state_reg <= 128'd0;
        end else if (accept) begin
            col_cnt   <= 2'd0;
            state_reg <= in_data;
        end else if (state == BUSY) begin
            case (col_cnt)
                2'd0:    state_reg[127:96] <= col_mixed;
                2'd1:    state_reg[95:64]  <= col_mixed;
                2'd2:    state_reg[63:32]  <= col_mixed;
                default: state_reg[31:0]   <= col_mixed;
            endcase
            col_cnt <= col_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_columns_seq
// Self-checking bench: directed vectors, back-to-back, backpressure, reset
// during BUSY, random blocks with random out_ready, and a column round trip
// through a forward MixColumns model and the inverse column unit.
// ---------------------------------------------------------------------------
module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic [31:0]  rt_in = '0;
    logic [31:0]  rt_out;

    int n_total = 0;
    int n_bad = 0;
    int n_sent = 0;
    int n_handoffs = 0;
    bit chk_en = 1'b0;
    bit rand_ready_en = 1'b0;

    // Reference model state: -1 idle, 1..4 columns still to process, 0 done.
    int           m_left = -1;
    logic [127:0] m_cur = '0;

    localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] VEC_FIX = 128'hc6c6c6c6_c6c6c6c6_01010101_00000000;

    always #5 clk = ~clk;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    inv_mix_column_32bit u_rt (
        .col_in  (rt_in),
        .col_out (rt_out)
    );

    // Carry-less multiply followed by reduction modulo 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [31:0] mat_col(input logic [31:0] x, input bit inverse);
        logic [7:0] m [4][4];
        logic [7:0] y;
        logic [31:0] r;
        if (inverse)
            m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                  '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        else
            m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                  '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
        r = '0;
        for (int row = 0; row < 4; row++) begin
            y = '0;
            for (int c = 0; c < 4; c++) y = y ^ gmul(m[row][c], x[31 - 8 * c -: 8]);
            r[31 - 8 * row -: 8] = y;
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_block(input logic [127:0] x);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) r[127 - 32 * c -: 32] = mat_col(x[127 - 32 * c -: 32], 1'b1);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [127:0] d, input bit r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    // Present a block and hold it until the bench sees in_ready, then return
    // just after the accepting edge with in_valid still high.
    task automatic sendBlock(input logic [127:0] d);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        if (got) n_sent++;
        else checkOutput("accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic waitValid(input string name, input logic [127:0] exp);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                checkOutput(name, out_data, exp);
            end
        end
        if (!seen) checkOutput({name, "_timeout"}, 128'd0, 128'd1);
    endtask

    // Per-cycle compare against the model, then advance the model to the
    // value it must have after the coming rising edge.
    always @(negedge clk) begin
        bit exp_valid;
        bit exp_ready;
        if (rst) begin
            m_left = -1;
            if (chk_en) begin
                checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
                checkOutput("rst_out_data", out_data, 128'd0);
            end
        end else if (chk_en) begin
            exp_valid = (m_left == 0);
            exp_ready = (m_left == -1) || (m_left == 0 && out_ready);
            checkOutput("out_valid", 128'(out_valid), 128'(exp_valid));
            checkOutput("in_ready", 128'(in_ready), 128'(exp_ready));
            if (exp_valid) checkOutput("out_data", out_data, m_cur);
            if (out_valid && out_ready) n_handoffs++;
            if (in_valid && exp_ready) begin
                m_cur  = inv_block(in_data);
                m_left = 4;
            end else if (m_left == 0 && out_ready) begin
                m_left = -1;
            end else if (m_left > 0) begin
                m_left--;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0]  x;
        logic [127:0] d;

        #1 rst = 1'b1;
        #1 chk_en = 1'b1;

        // Pin the reference model with hand-known values.
        checkOutput("model_gmul", 128'(gmul(8'h57, 8'h83)), 128'h00c1);
        checkOutput("model_vec", inv_block(VEC_IN), VEC_OUT);
        checkOutput("model_fix", inv_block(VEC_FIX), VEC_FIX);

        // Column round trip: forward model, then the inverse column unit.
        for (int i = 0; i < 10000; i++) begin
            x = $urandom;
            rt_in = mat_col(x, 1'b0);
            #1;
            checkOutput("roundtrip", 128'(rt_out), 128'(x));
        end

        // First accept on the first edge after reset release.
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, VEC_IN, 1'b1);
        sendBlock(VEC_IN);
        in_valid = 1'b0;
        waitValid("vec_known", VEC_OUT);
        repeat (3) @(posedge clk);
        #1;

        sendBlock(VEC_FIX);
        in_valid = 1'b0;
        waitValid("vec_fixed", VEC_FIX);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back with in_valid held high.
        sendBlock(128'h00112233_44556677_8899aabb_ccddeeff);
        sendBlock(128'hdeadbeef_01234567_89abcdef_fedcba98);
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Backpressure: hold result in DONE while a new block waits.
        out_ready = 1'b0;
        d = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
        sendBlock(d);
        in_valid = 1'b0;
        waitValid("bp_result", inv_block(d));
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_sent++;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Reset after column 1 of an in-flight block.
        sendBlock(128'h0badc0de_cafef00d_facefeed_12345678);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_busy_out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_busy_out_data", out_data, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        sendBlock(VEC_IN);
        in_valid = 1'b0;
        waitValid("after_rst", VEC_OUT);
        repeat (3) @(posedge clk);
        #1;

        // Random blocks with random gaps and random out_ready.
        rand_ready_en = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            sendBlock({$urandom, $urandom, $urandom, $urandom});
        end
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        rand_ready_en = 1'b0;
        #2;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Every accepted block except the one discarded by reset came out.
        checkOutput("handoff_count", 128'(n_handoffs), 128'(n_sent - 1));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
